// File: rtl/match_controller.sv
// Match controller: keeps left/right point scores, freezes play after each point
// and once the match is won, and drives the two score digits (winner's digit blinks).
module match_controller #(
  parameter int unsigned WIN_POINTS  = 7,
  parameter int unsigned PAUSE_TICKS = 16,
  parameter int unsigned BLINK_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic       left_point,
  input  logic       right_point,
  input  logic       new_match,
  output logic       freeze,
  output logic       match_over,
  output logic       winner,
  output logic [6:0] hex_left,
  output logic [6:0] hex_right
);

  typedef enum logic [1:0] {StPlay, StPause, StMatchOver} state_e;

  localparam logic [3:0] WinScore   = 4'(WIN_POINTS);
  localparam logic [7:0] PauseLoad  = 8'(PAUSE_TICKS);
  localparam logic [7:0] BlinkLimit = 8'(BLINK_TICKS);
  localparam logic [6:0] SegBlank   = 7'b1111111;

  state_e     state_q, state_d;
  logic [3:0] left_q, left_d;
  logic [3:0] right_q, right_d;
  logic [7:0] pause_q, pause_d;
  logic [7:0] blink_q, blink_d;
  logic       phase_q, phase_d;
  logic       winner_q, winner_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StPlay;
      left_q   <= 4'd0;
      right_q  <= 4'd0;
      pause_q  <= 8'd0;
      blink_q  <= 8'd0;
      phase_q  <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      pause_q  <= pause_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    right_d  = right_q;
    pause_d  = pause_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    winner_d = winner_q;

    if (new_match) begin
      state_d  = StPlay;
      left_d   = 4'd0;
      right_d  = 4'd0;
      pause_d  = 8'd0;
      blink_d  = 8'd0;
      phase_d  = 1'b0;
      winner_d = 1'b0;
    end else begin
      unique case (state_q)
        StPlay: begin
          // A tie (both pulses together) scores nothing.
          if (left_point ^ right_point) begin
            if (left_point) begin
              left_d = left_q + 4'd1;
            end else begin
              right_d = right_q + 4'd1;
            end
            if ((left_point && (left_q + 4'd1 == WinScore)) ||
                (right_point && (right_q + 4'd1 == WinScore))) begin
              state_d  = StMatchOver;
              winner_d = right_point;
              blink_d  = 8'd0;
              phase_d  = 1'b0;
            end else begin
              state_d = StPause;
              pause_d = PauseLoad;
            end
          end
        end
        StPause: begin
          if (CE) begin
            if (pause_q <= 8'd1) begin
              state_d = StPlay;
              pause_d = 8'd0;
            end else begin
              pause_d = pause_q - 8'd1;
            end
          end
        end
        StMatchOver: begin
          if (CE) begin
            if (blink_q + 8'd1 >= BlinkLimit) begin
              blink_d = 8'd0;
              phase_d = ~phase_q;
            end else begin
              blink_d = blink_q + 8'd1;
            end
          end
        end
        default: state_d = StPlay;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  logic blank_left, blank_right;

  always_comb begin
    freeze      = (state_q != StPlay);
    match_over  = (state_q == StMatchOver);
    winner      = match_over & winner_q;
    blank_left  = match_over & phase_q & ~winner_q;
    blank_right = match_over & phase_q & winner_q;
    hex_left    = blank_left  ? SegBlank : seg7(left_q);
    hex_right   = blank_right ? SegBlank : seg7(right_q);
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with WIN_POINTS=3, PAUSE_TICKS=2, BLINK_TICKS=2.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CE = 1'b0;
  logic       left_point = 1'b0;
  logic       right_point = 1'b0;
  logic       new_match = 1'b0;
  logic       freeze, match_over, winner;
  logic [6:0] hex_left, hex_right;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] DB = 7'b1111111;

  match_controller #(
    .WIN_POINTS (3),
    .PAUSE_TICKS(2),
    .BLINK_TICKS(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .CE         (CE),
    .left_point (left_point),
    .right_point(right_point),
    .new_match  (new_match),
    .freeze     (freeze),
    .match_over (match_over),
    .winner     (winner),
    .hex_left   (hex_left),
    .hex_right  (hex_right)
  );

  always #5 clk = ~clk;

  // CE: one clock high out of every four.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      CE = 1'b1;
      @(negedge clk);
      CE = 1'b0;
    end
  end

  // One-cycle pulse; returns on the negedge after the capturing posedge.
  task automatic pulse(input logic l, input logic r, input logic n);
    @(negedge clk);
    left_point = l;
    right_point = r;
    new_match = n;
    @(negedge clk);
    left_point = 1'b0;
    right_point = 1'b0;
    new_match = 1'b0;
  endtask

  // Counts CE edges until freeze drops; timed_out stays 1 if it never does.
  task automatic wait_unfreeze(output int ces, output bit timed_out);
    ces = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (CE) ces++;
      #1;
      if (!freeze) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (freeze !== 1'b0) begin
      failures++; $display("FAIL reset_freeze got=%b exp=0", freeze);
    end
    checks++;
    if (match_over !== 1'b0) begin
      failures++; $display("FAIL reset_match_over got=%b exp=0", match_over);
    end
    checks++;
    if (winner !== 1'b0) begin
      failures++; $display("FAIL reset_winner got=%b exp=0", winner);
    end
    checks++;
    if (hex_left !== D0 || hex_right !== D0) begin
      failures++;
      $display("FAIL reset_hex got=%b/%b exp=%b/%b", hex_left, hex_right, D0, D0);
    end
  endtask

  task automatic test_tie;
    pulse(1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (hex_left !== D0 || hex_right !== D0) begin
      failures++;
      $display("FAIL tie_hex got=%b/%b exp=%b/%b", hex_left, hex_right, D0, D0);
    end
    checks++;
    if (freeze !== 1'b0) begin
      failures++; $display("FAIL tie_freeze got=%b exp=0", freeze);
    end
  endtask

  task automatic test_point_pause;
    int  pre, ces;
    bit  to;
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (hex_left !== D1) begin
      failures++; $display("FAIL point_hex_left got=%b exp=%b", hex_left, D1);
    end
    checks++;
    if (freeze !== 1'b1) begin
      failures++; $display("FAIL point_freeze got=%b exp=1", freeze);
    end
    // A right point arriving during the pause must be dropped.
    pre = 0;
    right_point = 1'b1;
    @(posedge clk);
    if (CE) pre++;
    #1 right_point = 1'b0;
    @(negedge clk);
    checks++;
    if (hex_right !== D0) begin
      failures++; $display("FAIL pause_ignore_right got=%b exp=%b", hex_right, D0);
    end
    checks++;
    if (freeze !== 1'b1) begin
      failures++; $display("FAIL pause_still_frozen got=%b exp=1", freeze);
    end
    wait_unfreeze(ces, to);
    checks++;
    if (to || (pre + ces) != 2) begin
      failures++; $display("FAIL pause_ce_count got=%0d timeout=%0d exp=2", pre + ces, to);
    end
  endtask

  task automatic test_match_win;
    int         ces, k;
    bit         to;
    logic [6:0] exp_r;
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (hex_right !== D1) begin
      failures++; $display("FAIL right1_hex got=%b exp=%b", hex_right, D1);
    end
    wait_unfreeze(ces, to);
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (hex_right !== D2 || match_over !== 1'b0) begin
      failures++;
      $display("FAIL right2 got hex=%b mo=%b exp hex=%b mo=0", hex_right, match_over, D2);
    end
    wait_unfreeze(ces, to);
    checks++;
    if (to) begin
      failures++; $display("FAIL right2_unfreeze got=timeout exp=unfrozen");
    end
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (match_over !== 1'b1 || winner !== 1'b1 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL win_flags got mo=%b w=%b fr=%b exp 1/1/1", match_over, winner, freeze);
    end
    checks++;
    if (hex_right !== D3 || hex_left !== D1) begin
      failures++;
      $display("FAIL win_hex got=%b/%b exp=%b/%b", hex_left, hex_right, D1, D3);
    end
    // Phase toggles every 2 CE; points injected mid-blink must be ignored.
    k = 0;
    for (int i = 0; i < 60 && k < 6; i++) begin
      @(posedge clk);
      if (CE) begin
        k++;
        #1;
        exp_r = (((k / 2) % 2) == 1) ? DB : D3;
        checks++;
        if (hex_right !== exp_r || hex_left !== D1) begin
          failures++;
          $display("FAIL blink_ce%0d got=%b/%b exp=%b/%b", k, hex_left, hex_right, D1, exp_r);
        end
      end else begin
        #1;
      end
      left_point  = (i == 2);
      right_point = (i == 5);
    end
    left_point = 1'b0;
    right_point = 1'b0;
    checks++;
    if (k != 6 || match_over !== 1'b1) begin
      failures++; $display("FAIL blink_run got ces=%0d mo=%b exp ces=6 mo=1", k, match_over);
    end
  endtask

  task automatic test_new_match;
    pulse(1'b1, 1'b0, 1'b1);
    checks++;
    if (hex_left !== D0 || hex_right !== D0) begin
      failures++;
      $display("FAIL newm_hex got=%b/%b exp=%b/%b", hex_left, hex_right, D0, D0);
    end
    checks++;
    if (freeze !== 1'b0 || match_over !== 1'b0 || winner !== 1'b0) begin
      failures++;
      $display("FAIL newm_flags got fr=%b mo=%b w=%b exp 0/0/0", freeze, match_over, winner);
    end
  endtask

  task automatic test_reset_mid_pause;
    int ces;
    bit to;
    pulse(1'b1, 1'b0, 1'b0);
    wait_unfreeze(ces, to);
    pulse(1'b1, 1'b0, 1'b0);
    wait_unfreeze(ces, to);
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (hex_left !== D2 || hex_right !== D1 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL score_2_1 got=%b/%b fr=%b exp=%b/%b fr=1", hex_left, hex_right, freeze,
               D2, D1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (hex_left !== D0 || hex_right !== D0 || freeze !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%b fr=%b exp=%b/%b fr=0", hex_left, hex_right, freeze,
               D0, D0);
    end
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (hex_left !== D1 || hex_right !== D0 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_point got=%b/%b fr=%b exp=%b/%b fr=1", hex_left, hex_right,
               freeze, D1, D0);
    end
    wait_unfreeze(ces, to);
    checks++;
    if (to || ces != 2) begin
      failures++; $display("FAIL post_reset_pause got=%0d timeout=%0d exp=2", ces, to);
    end
  endtask

  initial begin
    test_reset;
    test_tie;
    test_point_pause;
    test_match_win;
    test_new_match;
    test_reset_mid_pause;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
